// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: opcodes, ALU control word, FSM states.
package alu_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'd0,
    OP_ADDINC = 4'd1,
    OP_OR     = 4'd2,
    OP_AND    = 4'd3,
    OP_XOR    = 4'd4,
    OP_NEGA   = 4'd5,
    OP_MULR   = 4'd6,
    OP_NOP    = 4'd7
  } op_e;

  typedef struct packed {
    logic f1;
    logic f0;
    logic ena;
    logic enb;
    logic inva;
    logic inc;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_ADD    = alu_ctrl_t'(6'b001100);
  localparam alu_ctrl_t CTRL_ADDINC = alu_ctrl_t'(6'b001101);
  localparam alu_ctrl_t CTRL_OR     = alu_ctrl_t'(6'b011100);
  localparam alu_ctrl_t CTRL_AND    = alu_ctrl_t'(6'b111100);
  localparam alu_ctrl_t CTRL_XOR    = alu_ctrl_t'(6'b101100);
  localparam alu_ctrl_t CTRL_NEGA   = alu_ctrl_t'(6'b001111);
  localparam alu_ctrl_t CTRL_NOP    = alu_ctrl_t'(6'b000000);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Op request, ALU drive/return and result handshake bundle for the sequencer.
interface alu_sequencer_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [CNT_W-1:0] op_count;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [5:0]       alu_ctrl;
  logic [N-1:0]     alu_func;
  logic             alu_ovf;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_ovf;
  logic             res_err;

  modport slave (
    input  op_valid, op_code, op_a, op_b, op_count, alu_func, alu_ovf, res_ready,
    output op_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_ovf, res_err
  );

  modport master (
    output op_valid, op_code, op_a, op_b, op_count, alu_func, alu_ovf, res_ready,
    input  op_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_ovf, res_err
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Opcode to ALU control word decode; shared with the microcode path.
module alu_op_decoder
  import alu_pkg::*;
(
  input  op_e       i_op,
  output alu_ctrl_t o_ctrl_c,
  output logic      o_illegal_c
);

  always_comb begin
    o_ctrl_c    = CTRL_NOP;
    o_illegal_c = 1'b0;
    case (i_op)
      OP_ADD, OP_MULR: o_ctrl_c = CTRL_ADD;
      OP_ADDINC:       o_ctrl_c = CTRL_ADDINC;
      OP_OR:           o_ctrl_c = CTRL_OR;
      OP_AND:          o_ctrl_c = CTRL_AND;
      OP_XOR:          o_ctrl_c = CTRL_XOR;
      OP_NEGA:         o_ctrl_c = CTRL_NEGA;
      OP_NOP:          o_ctrl_c = CTRL_NOP;
      default:         o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU op (or a repeated-add MULR) per request and returns the result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  state_e           r_state,    w_state_nxt;
  op_e              r_op,       w_op_nxt;
  logic             r_illegal,  w_illegal_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [N-1:0]     r_alu_a,    w_alu_a_nxt;
  logic [N-1:0]     r_alu_b,    w_alu_b_nxt;
  alu_ctrl_t        r_alu_ctrl, w_alu_ctrl_nxt;
  logic [N-1:0]     r_res_data, w_res_data_nxt;
  logic             r_res_ovf,  w_res_ovf_nxt;
  logic             r_res_err,  w_res_err_nxt;
  logic             r_op_ready, w_op_ready_nxt;
  logic             r_res_valid, w_res_valid_nxt;

  op_e       w_in_op;
  alu_ctrl_t w_dec_ctrl;
  logic      w_dec_illegal;

  assign w_in_op = op_e'(bus.op_code);

  alu_op_decoder u_dec (
    .i_op        (w_in_op),
    .o_ctrl_c    (w_dec_ctrl),
    .o_illegal_c (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= CTRL_NOP;
      r_res_data  <= '0;
      r_res_ovf   <= 1'b0;
      r_res_err   <= 1'b0;
      r_op_ready  <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_illegal   <= w_illegal_nxt;
      r_cnt       <= w_cnt_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_ctrl  <= w_alu_ctrl_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_ovf   <= w_res_ovf_nxt;
      r_res_err   <= w_res_err_nxt;
      r_op_ready  <= w_op_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  // Next-state and next-output logic; ALU drive is non-zero only while in EXEC.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_illegal_nxt  = r_illegal;
    w_cnt_nxt      = r_cnt;
    w_alu_a_nxt    = r_alu_a;
    w_alu_b_nxt    = r_alu_b;
    w_alu_ctrl_nxt = r_alu_ctrl;
    w_res_data_nxt = r_res_data;
    w_res_ovf_nxt  = r_res_ovf;
    w_res_err_nxt  = r_res_err;

    case (r_state)
      ST_IDLE: begin
        if (bus.op_valid) begin
          w_op_nxt       = w_in_op;
          w_illegal_nxt  = w_dec_illegal;
          w_cnt_nxt      = bus.op_count;
          w_res_data_nxt = '0;
          w_res_ovf_nxt  = 1'b0;
          w_res_err_nxt  = 1'b0;
          w_alu_ctrl_nxt = w_dec_ctrl;
          w_alu_a_nxt    = '0;
          w_alu_b_nxt    = '0;
          w_state_nxt    = ST_EXEC;
          if (w_in_op == OP_MULR) begin
            if (bus.op_count == '0) begin
              w_state_nxt    = ST_DONE;
              w_alu_ctrl_nxt = CTRL_NOP;
            end else begin
              w_alu_b_nxt = bus.op_b;
            end
          end else if (!w_dec_illegal && w_in_op != OP_NOP) begin
            w_alu_a_nxt = bus.op_a;
            w_alu_b_nxt = bus.op_b;
          end
        end
      end

      ST_EXEC: begin
        if (r_op == OP_MULR) begin
          w_res_ovf_nxt = r_res_ovf | bus.alu_ovf;
          w_cnt_nxt     = r_cnt - CNT_W'(1);
          w_alu_a_nxt   = bus.alu_func;
          if (r_cnt == CNT_W'(1)) begin
            w_res_data_nxt = bus.alu_func;
            w_state_nxt    = ST_DONE;
          end
        end else begin
          w_res_data_nxt = (r_illegal || r_op == OP_NOP) ? '0 : bus.alu_func;
          w_res_ovf_nxt  = (r_illegal || r_op == OP_NOP) ? 1'b0 : bus.alu_ovf;
          w_res_err_nxt  = r_illegal;
          w_state_nxt    = ST_DONE;
        end
        if (w_state_nxt == ST_DONE) begin
          w_alu_a_nxt    = '0;
          w_alu_b_nxt    = '0;
          w_alu_ctrl_nxt = CTRL_NOP;
        end
      end

      ST_DONE: begin
        if (bus.res_ready) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_op_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_res_valid_nxt = (w_state_nxt == ST_DONE);
  end

  assign bus.op_ready  = r_op_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_ovf   = r_res_ovf;
  assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a behavioural model of the 16-bit ALU.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.N(16), .CNT_W(8)) bus ();

  alu_sequencer #(.N(16), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU model: {F1,F0} 00 add, 01 or, 11 and, 10 xor; carry-out is Ovflag.
  logic [15:0] m_ax, m_bx;
  logic [16:0] m_sum;
  always_comb begin
    m_ax = bus.alu_ctrl[3] ? bus.alu_a : 16'h0000;
    if (bus.alu_ctrl[1]) m_ax = ~m_ax;
    m_bx  = bus.alu_ctrl[2] ? bus.alu_b : 16'h0000;
    m_sum = {1'b0, m_ax} + {1'b0, m_bx} + 17'(bus.alu_ctrl[0]);
    bus.alu_ovf = 1'b0;
    case (bus.alu_ctrl[5:4])
      2'b00: begin bus.alu_func = m_sum[15:0]; bus.alu_ovf = m_sum[16]; end
      2'b01: bus.alu_func = m_ax | m_bx;
      2'b11: bus.alu_func = m_ax & m_bx;
      default: bus.alu_func = m_ax ^ m_bx;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] code, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] cnt, input int exp_lat,
                        input logic [5:0] exp_ctrl, input logic [15:0] exp_a0,
                        input logic [15:0] exp_data, input logic exp_ovf, input logic exp_err);
    int lat;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_count = cnt;
    tick();
    bus.op_valid = 1'b0;
    check({tag, "_busy_ready"}, 32'(bus.op_ready), 32'd0);
    if (exp_lat > 1) begin
      check({tag, "_exec_ctrl"}, 32'(bus.alu_ctrl), 32'(exp_ctrl));
      check({tag, "_exec_a"}, 32'(bus.alu_a), 32'(exp_a0));
    end else begin
      check({tag, "_ctrl_idle"}, 32'(bus.alu_ctrl), 32'd0);
    end
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
    check({tag, "_ovf"}, 32'(bus.res_ovf), 32'(exp_ovf));
    check({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.op_ready), 32'd1);
    check({tag, "_ctrl_after"}, 32'(bus.alu_ctrl), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_code   = 4'h0;
    bus.op_a      = 16'h0000;
    bus.op_b      = 16'h0000;
    bus.op_count  = 8'd0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_ovf", 32'(bus.res_ovf), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    rst = 1'b0;

    // res_ready with nothing pending has no effect
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("idle_rdy_valid", 32'(bus.res_valid), 32'd0);
    check("idle_rdy_ready", 32'(bus.op_ready), 32'd1);

    run_op("add",     4'h0, 16'h0003, 16'h0004, 8'd0, 2, 6'b001100, 16'h0003, 16'h0007, 1'b0, 1'b0);
    run_op("add_wrap",4'h0, 16'hFFFF, 16'h0001, 8'd0, 2, 6'b001100, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("addinc",  4'h1, 16'h0003, 16'h0004, 8'd0, 2, 6'b001101, 16'h0003, 16'h0008, 1'b0, 1'b0);
    run_op("or",      4'h2, 16'h00F0, 16'h0F0F, 8'd0, 2, 6'b011100, 16'h00F0, 16'h0FFF, 1'b0, 1'b0);
    run_op("and",     4'h3, 16'h00FF, 16'h0F0F, 8'd0, 2, 6'b111100, 16'h00FF, 16'h000F, 1'b0, 1'b0);
    run_op("xor",     4'h4, 16'h00FF, 16'h0F0F, 8'd0, 2, 6'b101100, 16'h00FF, 16'h0FF0, 1'b0, 1'b0);
    run_op("nega",    4'h5, 16'h0003, 16'h0000, 8'd0, 2, 6'b001111, 16'h0003, 16'hFFFD, 1'b0, 1'b0);
    run_op("mulr3",   4'h6, 16'h1234, 16'h0005, 8'd3, 4, 6'b001100, 16'h0000, 16'h000F, 1'b0, 1'b0);
    run_op("mulr0",   4'h6, 16'h1234, 16'h0005, 8'd0, 1, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("mulr_ovf",4'h6, 16'h0000, 16'h8000, 8'd3, 4, 6'b001100, 16'h0000, 16'h8000, 1'b1, 1'b0);
    run_op("nop",     4'h7, 16'h0005, 16'h0006, 8'd0, 2, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("illegal", 4'hA, 16'h0005, 16'h0006, 8'd0, 2, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("err_clr", 4'h0, 16'h0010, 16'h0020, 8'd0, 2, 6'b001100, 16'h0010, 16'h0030, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles while a competing op pulse is ignored
    bus.op_valid = 1'b1;
    bus.op_code  = 4'h0;
    bus.op_a     = 16'h0001;
    bus.op_b     = 16'h0002;
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("bp_first_valid", 32'(bus.res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.op_valid = (i == 1);
      bus.op_code  = 4'h2;
      bus.op_a     = 16'hAAAA;
      bus.op_b     = 16'h5555;
      tick();
      check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      check("bp_hold_data", 32'(bus.res_data), 32'h0003);
      check("bp_hold_ready", 32'(bus.op_ready), 32'd0);
      check("bp_hold_ctrl", 32'(bus.alu_ctrl), 32'd0);
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_release_valid", 32'(bus.res_valid), 32'd0);
    check("bp_release_ready", 32'(bus.op_ready), 32'd1);
    tick();
    check("bp_no_late_op", 32'(bus.alu_ctrl), 32'd0);

    // Reset during a long MULR aborts it and drops the result
    bus.op_valid = 1'b1;
    bus.op_code  = 4'h6;
    bus.op_b     = 16'h0001;
    bus.op_count = 8'd10;
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("abort_in_exec", 32'(bus.alu_ctrl), 32'(6'b001100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(bus.res_valid), 32'd0);
    check("abort_ready", 32'(bus.op_ready), 32'd1);
    check("abort_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("abort_alu_a", 32'(bus.alu_a), 32'd0);
    check("abort_data", 32'(bus.res_data), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_result", 32'(bus.res_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
